// File: rtl/mux4_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux4_arb_pkg
// Shared definitions for the 4-requester round-robin arbiter:
//   NUM_REQ / SEL_W   requester count and index width
//   req_idx_t         requester index type
//   pick_t            {found, idx} result of a rotating priority scan
//   rr_next()         first valid requester after 'base', wrapping, with
//                     'base' itself examined last
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] req_idx_t;

    typedef struct packed {
        logic     found;
        req_idx_t idx;
    } pick_t;

    // Scan order base+1, base+2, base+3, base (mod 4). The 2-bit index
    // arithmetic provides the wrap for free.
    function automatic pick_t rr_next(input req_idx_t base, input logic [NUM_REQ-1:0] valid);
        pick_t    r;
        req_idx_t cand;
        r = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = base + req_idx_t'(k);
            if (!r.found && valid[cand]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundles the four requester valid/ready/bits channels and the single
// downstream valid/ready stream of the arbiter.
//   io_in_N_valid/bits  requester N beat (driven by master)
//   io_in_N_ready       requester N accepted this cycle (driven by slave)
//   io_out_valid/bits   output register contents (driven by slave)
//   io_out_chosen       source index of io_out_bits (driven by slave)
//   io_out_ready        downstream accepts beat (driven by master)
// Modports: master = requesters + consumer side, slave = arbiter.
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic             io_in_0_valid;
    logic             io_in_1_valid;
    logic             io_in_2_valid;
    logic             io_in_3_valid;
    logic [WIDTH-1:0] io_in_0_bits;
    logic [WIDTH-1:0] io_in_1_bits;
    logic [WIDTH-1:0] io_in_2_bits;
    logic [WIDTH-1:0] io_in_3_bits;
    logic             io_in_0_ready;
    logic             io_in_1_ready;
    logic             io_in_2_ready;
    logic             io_in_3_ready;

    logic             io_out_valid;
    logic [WIDTH-1:0] io_out_bits;
    req_idx_t         io_out_chosen;
    logic             io_out_ready;

    modport master (
        output io_in_0_valid, io_in_1_valid, io_in_2_valid, io_in_3_valid,
        output io_in_0_bits,  io_in_1_bits,  io_in_2_bits,  io_in_3_bits,
        input  io_in_0_ready, io_in_1_ready, io_in_2_ready, io_in_3_ready,
        input  io_out_valid,  io_out_bits,   io_out_chosen,
        output io_out_ready
    );

    modport slave (
        input  io_in_0_valid, io_in_1_valid, io_in_2_valid, io_in_3_valid,
        input  io_in_0_bits,  io_in_1_bits,  io_in_2_bits,  io_in_3_bits,
        output io_in_0_ready, io_in_1_ready, io_in_2_ready, io_in_3_ready,
        output io_out_valid,  io_out_bits,   io_out_chosen,
        input  io_out_ready
    );

endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// mux4_rr_pick
// Combinational rotating priority encoder.
//   i_base   current owner; scan starts just after it
//   i_valid  per-requester valid
//   o_grant  selected requester (meaningful only when o_found)
//   o_found  at least one requester valid
// ---------------------------------------------------------------------------
module mux4_rr_pick
    import mux4_arb_pkg::*;
(
    input  req_idx_t           i_base,
    input  logic [NUM_REQ-1:0] i_valid,
    output req_idx_t           o_grant,
    output logic               o_found
);

    pick_t w_pick;

    assign w_pick  = rr_next(i_base, i_valid);
    assign o_grant = w_pick.idx;
    assign o_found = w_pick.found;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Shares one 4:1 byte-select datapath between four valid/ready requesters
// using round-robin arbitration with an optional per-owner burst hold, and
// presents the result through a registered one-beat output stage tagged
// with the source index.
//   clock   single clock, rising edge
//   reset   asynchronous, active-low
//   bus     mux4_rr_arbiter_if.slave (requester channels + output stream)
// Parameters: WIDTH data bits per beat, BURST max consecutive beats per
// owner before rotation is forced (>=1).
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input logic              clock,
    input logic              reset,
    mux4_rr_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic             r_vld_p1;
    logic [WIDTH-1:0] r_bits_p1;
    req_idx_t         r_chosen_p1;
    req_idx_t         r_owner;
    logic [CNT_W-1:0] r_cnt;

    logic [NUM_REQ-1:0] w_valid;
    logic [WIDTH-1:0]   w_bits [NUM_REQ];
    logic               w_can_load;
    logic               w_hold;
    req_idx_t           w_pick_idx;
    logic               w_pick_found;
    req_idx_t           w_gnt_idx;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_ready;
    logic [WIDTH-1:0]   w_sel_bits;
    logic [CNT_W-1:0]   w_cnt_next;

    assign w_valid   = {bus.io_in_3_valid, bus.io_in_2_valid, bus.io_in_1_valid, bus.io_in_0_valid};
    assign w_bits[0] = bus.io_in_0_bits;
    assign w_bits[1] = bus.io_in_1_bits;
    assign w_bits[2] = bus.io_in_2_bits;
    assign w_bits[3] = bus.io_in_3_bits;

    // The output slot is free if empty or being drained this same cycle;
    // the io_out_ready -> io_in_N_ready combinational path is deliberate.
    assign w_can_load = !r_vld_p1 || bus.io_out_ready;

    // The owner keeps the grant while its burst is open and it still has data.
    assign w_hold = (r_cnt != '0) && (r_cnt < BURST_C) && w_valid[r_owner];

    mux4_rr_pick u_pick (
        .i_base  (r_owner),
        .i_valid (w_valid),
        .o_grant (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_gnt_idx = w_hold ? r_owner : w_pick_idx;

    // A grant always targets a valid requester, so grant == transfer.
    // Gating with reset keeps every ready low while reset is held.
    assign w_xfer = reset && w_can_load && (w_hold || w_pick_found);

    always_comb begin
        w_ready = '0;
        if (w_xfer) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign bus.io_in_0_ready = w_ready[0];
    assign bus.io_in_1_ready = w_ready[1];
    assign bus.io_in_2_ready = w_ready[2];
    assign bus.io_in_3_ready = w_ready[3];

    assign w_sel_bits = w_bits[w_gnt_idx];

    // Re-granting the owner extends its burst; any other grant (including
    // the owner winning again after a full burst) starts a new one.
    assign w_cnt_next = ((w_gnt_idx == r_owner) && (r_cnt < BURST_C)) ? r_cnt + ONE_C : ONE_C;

    // ---- stage p0 -> p1: arbitration result captured into output register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld_p1    <= 1'b0;
            r_bits_p1   <= '0;
            r_chosen_p1 <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
        end else if (w_xfer) begin
            r_vld_p1    <= 1'b1;
            r_bits_p1   <= w_sel_bits;
            r_chosen_p1 <= w_gnt_idx;
            r_owner     <= w_gnt_idx;
            r_cnt       <= w_cnt_next;
        end else if (r_vld_p1 && bus.io_out_ready) begin
            r_vld_p1    <= 1'b0;
        end
    end

    assign bus.io_out_valid  = r_vld_p1;
    assign bus.io_out_bits   = r_bits_p1;
    assign bus.io_out_chosen = r_chosen_p1;

endmodule
